// File: rtl/lsu.sv
// Load/store unit: accepts one load or store per transaction, checks RV32I
// alignment, steers store bytes onto the word lanes and builds the write mask,
// holds the memory access for LATENCY cycles, and returns extended load data.
module lsu #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_wen,
    output logic        mem_valid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        illegal;
    logic        in_access;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] steer_data;
    logic [3:0]  steer_mask;

    // Decode the incoming request for misalignment or an unsupported funct3.
    always_comb begin
        illegal = 1'b1;
        if (req_wen) begin
            unique case (req_funct3)
                3'b000:  illegal = 1'b0;
                3'b001:  illegal = req_addr[0];
                3'b010:  illegal = (req_addr[1:0] != 2'b00);
                default: illegal = 1'b1;
            endcase
        end else begin
            unique case (req_funct3)
                3'b000, 3'b100: illegal = 1'b0;
                3'b001, 3'b101: illegal = req_addr[0];
                3'b010:         illegal = (req_addr[1:0] != 2'b00);
                default:        illegal = 1'b1;
            endcase
        end
    end

    // Extract and extend the addressed byte/half/word from the read word.
    always_comb begin
        shifted   = mem_rdata >> {addr_q[1:0], 3'b000};
        load_data = 32'h0;
        unique case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = shifted;
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase
    end

    // Replicate store data across lanes so the mask alone selects the bytes.
    always_comb begin
        steer_data = 32'h0;
        steer_mask = 4'h0;
        unique case (funct3_q)
            3'b000: begin
                steer_data = {4{wdata_q[7:0]}};
                steer_mask = 4'b0001 << addr_q[1:0];
            end
            3'b001: begin
                steer_data = {2{wdata_q[15:0]}};
                steer_mask = 4'b0011 << {addr_q[1], 1'b0};
            end
            3'b010: begin
                steer_data = wdata_q;
                steer_mask = 4'b1111;
            end
            default: begin
                steer_data = 32'h0;
                steer_mask = 4'h0;
            end
        endcase
    end

    // Next-state logic for the transaction FSM and its captured fields.
    always_comb begin
        state_d  = state_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d    = req_wen;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    rdata_d  = 32'h0;
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = 4'(LATENCY);
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!wen_q) begin
                        rdata_d = load_data;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wen_q    <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'b000;
            cnt_q    <= 4'd0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs; rst gates the memory side so it drops without waiting for a clock.
    always_comb begin
        in_access  = (state_q == ACCESS) && !rst;
        req_ready  = (state_q == IDLE) && !rst;
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_valid  = in_access;
        mem_raddr  = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_waddr  = mem_raddr;
        mem_wen    = in_access && wen_q && (cnt_q == 4'd1);
        mem_wdata  = (in_access && wen_q) ? steer_data : 32'h0;
        mem_wmask  = {4'h0, ((in_access && wen_q) ? steer_mask : 4'h0)};
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: three instances (LATENCY 1, 3, 4) share one request
// stream; each step targets the instance whose latency the scenario needs.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_ready;
    logic [31:0] mem_rdata;

    logic        req_ready  [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];
    logic [31:0] mem_raddr  [3];
    logic [31:0] mem_waddr  [3];
    logic [31:0] mem_wdata  [3];
    logic [7:0]  mem_wmask  [3];
    logic        mem_wen    [3];
    logic        mem_valid  [3];

    int checks = 0;
    int errors = 0;
    int wen_cnt2 = 0;
    int wen_snap;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int unsigned L = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
        lsu #(.LATENCY(L)) u_lsu (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid),
            .req_ready  (req_ready[gi]),
            .req_wen    (req_wen),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .req_funct3 (req_funct3),
            .resp_valid (resp_valid[gi]),
            .resp_ready (resp_ready),
            .resp_rdata (resp_rdata[gi]),
            .resp_err   (resp_err[gi]),
            .mem_raddr  (mem_raddr[gi]),
            .mem_waddr  (mem_waddr[gi]),
            .mem_wdata  (mem_wdata[gi]),
            .mem_wmask  (mem_wmask[gi]),
            .mem_wen    (mem_wen[gi]),
            .mem_valid  (mem_valid[gi]),
            .mem_rdata  (mem_rdata)
        );
    end

    // Count write strobes of the LATENCY=4 instance.
    always @(posedge clk) begin
        if (mem_wen[2]) wen_cnt2 <= wen_cnt2 + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f);
        req_wen    = w;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f;
        req_valid  = 1'b1;
        step();
        // Scramble fields after handshake; the captured copy must be used.
        req_valid  = 1'b0;
        req_wen    = ~w;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0;
        req_funct3 = 3'b111;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_funct3 = 3'b000; resp_ready = 1'b0; mem_rdata = 32'h0;

        // Reset state
        step(); step();
        check("rst_req_ready", req_ready[0], 1'b0);
        check("rst_resp_valid", resp_valid[0], 1'b0);
        check("rst_mem_valid", mem_valid[0], 1'b0);
        check("rst_resp_rdata", resp_rdata[0], 32'h0);
        rst = 1'b0;
        #1;
        check("rel_req_ready", req_ready[0], 1'b1);
        resp_ready = 1'b1;
        step();

        // lw, LATENCY=1
        mem_rdata = 32'hDEAD_BEEF;
        issue(1'b0, 32'h8000_0004, 32'h0, 3'b010);
        check("lw_mem_valid", mem_valid[0], 1'b1);
        check("lw_mem_raddr", mem_raddr[0], 32'h8000_0004);
        check("lw_mem_waddr", mem_waddr[0], 32'h8000_0004);
        check("lw_mem_wen", mem_wen[0], 1'b0);
        check("lw_req_ready_busy", req_ready[0], 1'b0);
        check("lw_resp_early", resp_valid[0], 1'b0);
        step();
        check("lw_mem_valid_off", mem_valid[0], 1'b0);
        check("lw_resp_valid", resp_valid[0], 1'b1);
        check("lw_resp_rdata", resp_rdata[0], 32'hDEAD_BEEF);
        check("lw_resp_err", resp_err[0], 1'b0);
        step();
        check("lw_req_ready_back", req_ready[0], 1'b1);
        repeat (8) step();

        // lb / lbu at offset 3, lh / lhu at offset 2
        mem_rdata = 32'h80FF_7F01;
        issue(1'b0, 32'h8000_0003, 32'h0, 3'b000);
        step();
        check("lb_rdata", resp_rdata[0], 32'hFFFF_FF80);
        repeat (8) step();
        issue(1'b0, 32'h8000_0003, 32'h0, 3'b100);
        step();
        check("lbu_rdata", resp_rdata[0], 32'h0000_0080);
        repeat (8) step();
        issue(1'b0, 32'h8000_0002, 32'h0, 3'b001);
        step();
        check("lh_rdata", resp_rdata[0], 32'hFFFF_80FF);
        repeat (8) step();
        issue(1'b0, 32'h8000_0002, 32'h0, 3'b101);
        step();
        check("lhu_rdata", resp_rdata[0], 32'h0000_80FF);
        repeat (8) step();

        // sb then sh, LATENCY=3
        issue(1'b1, 32'h8000_0002, 32'h1234_56AB, 3'b000);
        for (int c = 0; c < 3; c++) begin
            check("sb_mem_valid", mem_valid[1], 1'b1);
            check("sb_mem_wen", mem_wen[1], (c == 2));
            check("sb_mem_wdata", mem_wdata[1], 32'hABAB_ABAB);
            check("sb_mem_wmask", mem_wmask[1], 8'h04);
            check("sb_mem_waddr", mem_waddr[1], 32'h8000_0000);
            step();
        end
        check("sb_mem_valid_off", mem_valid[1], 1'b0);
        check("sb_resp_valid", resp_valid[1], 1'b1);
        check("sb_resp_rdata", resp_rdata[1], 32'h0);
        check("sb_resp_err", resp_err[1], 1'b0);
        repeat (8) step();
        issue(1'b1, 32'h8000_0002, 32'h0000_BEEF, 3'b001);
        for (int c = 0; c < 3; c++) begin
            check("sh_mem_valid", mem_valid[1], 1'b1);
            check("sh_mem_wen", mem_wen[1], (c == 2));
            check("sh_mem_wdata", mem_wdata[1], 32'hBEEF_BEEF);
            check("sh_mem_wmask", mem_wmask[1], 8'h0C);
            step();
        end
        check("sh_resp_valid", resp_valid[1], 1'b1);
        repeat (8) step();

        // Illegal requests: no memory access, immediate error response
        issue(1'b0, 32'h8000_0002, 32'h0, 3'b010);
        check("err_lw_valid", resp_valid[0], 1'b1);
        check("err_lw_err", resp_err[0], 1'b1);
        check("err_lw_rdata", resp_rdata[0], 32'h0);
        for (int i = 0; i < 3; i++) check("err_lw_mem_valid", mem_valid[i], 1'b0);
        step();
        check("err_lw_idle", req_ready[0], 1'b1);
        issue(1'b0, 32'h8000_0001, 32'h0, 3'b001);
        check("err_lh_err", resp_err[0], 1'b1);
        check("err_lh_rdata", resp_rdata[0], 32'h0);
        for (int i = 0; i < 3; i++) check("err_lh_mem_valid", mem_valid[i], 1'b0);
        step();
        issue(1'b0, 32'h8000_0000, 32'h0, 3'b011);
        check("err_f3_err", resp_err[0], 1'b1);
        check("err_f3_valid", resp_valid[0], 1'b1);
        for (int i = 0; i < 3; i++) check("err_f3_mem_valid", mem_valid[i], 1'b0);
        step();
        issue(1'b1, 32'h8000_0000, 32'h0, 3'b100);
        check("err_sf3_err", resp_err[0], 1'b1);
        check("err_sf3_mem_valid", mem_valid[2], 1'b0);
        repeat (8) step();

        // Response backpressure
        resp_ready = 1'b0;
        mem_rdata  = 32'h1122_3344;
        issue(1'b0, 32'h8000_0008, 32'h0, 3'b010);
        step();
        for (int c = 0; c < 5; c++) begin
            check("bp_resp_valid", resp_valid[0], 1'b1);
            check("bp_resp_rdata", resp_rdata[0], 32'h1122_3344);
            check("bp_resp_err", resp_err[0], 1'b0);
            check("bp_req_ready", req_ready[0], 1'b0);
            mem_rdata = ~mem_rdata;
            step();
        end
        resp_ready = 1'b1;
        step();
        check("bp_req_ready_back", req_ready[0], 1'b1);
        check("bp_resp_valid_off", resp_valid[0], 1'b0);
        repeat (8) step();

        // Reset during the 2nd ACCESS cycle of a sw, LATENCY=4
        wen_snap = wen_cnt2;
        issue(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 3'b010);
        check("rs_mem_valid1", mem_valid[2], 1'b1);
        check("rs_mem_wmask", mem_wmask[2], 8'h0F);
        check("rs_mem_wdata", mem_wdata[2], 32'hCAFE_F00D);
        step();
        check("rs_mem_valid2", mem_valid[2], 1'b1);
        check("rs_mem_wen2", mem_wen[2], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rs_async_mem_valid", mem_valid[2], 1'b0);
        check("rs_async_mem_wen", mem_wen[2], 1'b0);
        check("rs_async_req_ready", req_ready[2], 1'b0);
        check("rs_async_resp_valid", resp_valid[2], 1'b0);
        step(); step();
        rst = 1'b0;
        #1;
        check("rs_rel_req_ready", req_ready[2], 1'b1);
        repeat (6) step();
        check("rs_no_wen", wen_cnt2, wen_snap);

        // lw after reset completes normally
        mem_rdata = 32'h55AA_55AA;
        issue(1'b0, 32'h8000_000C, 32'h0, 3'b010);
        for (int c = 0; c < 4; c++) begin
            check("post_mem_valid", mem_valid[2], 1'b1);
            check("post_mem_raddr", mem_raddr[2], 32'h8000_000C);
            check("post_mem_wen", mem_wen[2], 1'b0);
            step();
        end
        check("post_resp_valid", resp_valid[2], 1'b1);
        check("post_resp_rdata", resp_rdata[2], 32'h55AA_55AA);
        check("post_resp_err", resp_err[2], 1'b0);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
